// File: rtl/fp_round_pack.sv
// fp_round_pack: round-half-up, saturate and pack {S,E[2:0],F[3:0]} in a 2-stage valid/ready pipeline
//  clk, rst            : clock, synchronous active-high reset
//  in_valid/in_ready   : upstream handshake; in_sign, in_exponent, in_significand, in_fifth_bit
//  out_valid/out_ready : downstream handshake; out_float = {S, E[2:0], F[3:0]}
//  round_cnt, sat_cnt  : saturating counts of delivered rounded / clamped words
module fp_round_pack #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [2:0]         in_exponent,
  input  logic [3:0]         in_significand,
  input  logic               in_fifth_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_float,
  output logic [COUNT_W-1:0] round_cnt,
  output logic [COUNT_W-1:0] sat_cnt
);
  logic               s1_valid_q, s1_valid_d, s1_sign_q, s1_fifth_q;
  logic [2:0]         s1_exp_q;
  logic [3:0]         s1_sig_q;
  logic               out_valid_q, out_valid_d, s2_rnd_q, s2_rnd_d, s2_sat_q, s2_sat_d;
  logic [7:0]         out_float_q, out_float_d;
  logic [COUNT_W-1:0] round_cnt_q, round_cnt_d, sat_cnt_q, sat_cnt_d;
  logic [4:0]         sum;
  logic               carry, sat, rnd, s2_load, take, deliver;
  logic [2:0]         r_exp;
  logic [3:0]         r_sig;
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign take      = in_valid && in_ready;
  assign deliver   = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_float = out_float_q;
  assign round_cnt = round_cnt_q;
  assign sat_cnt   = sat_cnt_q;
  // carry out of F+fifth bumps E; at E=7 the word clamps to max magnitude instead
  always_comb begin
    sum         = {1'b0, s1_sig_q} + {4'b0, s1_fifth_q};
    carry       = sum[4];
    sat         = carry && (s1_exp_q == 3'd7);
    rnd         = s1_fifth_q && !sat;
    r_exp       = (carry && !sat) ? s1_exp_q + 3'd1 : s1_exp_q;
    r_sig       = sat ? 4'hf : carry ? 4'h8 : sum[3:0];
    s1_valid_d  = take ? 1'b1 : s2_load ? 1'b0 : s1_valid_q;
    out_valid_d = s2_load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_float_d = s2_load ? {s1_sign_q, r_exp, r_sig} : out_float_q;
    s2_rnd_d    = s2_load ? rnd : s2_rnd_q;
    s2_sat_d    = s2_load ? sat : s2_sat_q;
    round_cnt_d = (deliver && s2_rnd_q && !(&round_cnt_q)) ? round_cnt_q + 1'b1 : round_cnt_q;
    sat_cnt_d   = (deliver && s2_sat_q && !(&sat_cnt_q)) ? sat_cnt_q + 1'b1 : sat_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_float_q <= '0;
      s2_rnd_q    <= 1'b0;
      s2_sat_q    <= 1'b0;
      round_cnt_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_float_q <= out_float_d;
      s2_rnd_q    <= s2_rnd_d;
      s2_sat_q    <= s2_sat_d;
      round_cnt_q <= round_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (take) begin
      s1_sign_q  <= in_sign;
      s1_exp_q   <= in_exponent;
      s1_sig_q   <= in_significand;
      s1_fifth_q <= in_fifth_bit;
    end
  end
endmodule
